// File: rtl/mem_access_unit_if.sv
// RAM-side request/acknowledge bus between the memory-access stage and the data RAM.
// The master drives the request fields; the slave returns read data and the acknowledge.
interface mem_access_unit_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              ack;

   modport master (
      output req,
      output we,
      output addr,
      output be,
      output wdata,
      input  rdata,
      input  ack
   );

   modport slave (
      input  req,
      input  we,
      input  addr,
      input  be,
      input  wdata,
      output rdata,
      output ack
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage: turns an ALU byte address into a RAM word access (LW/LB/SW/SB),
// runs the req/ack handshake with a timeout, and holds the last loaded value for write-back.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | waiting for start_i; request legality decided here
//   S_REQ  | mem.req held high with latched fields, waiting for mem.ack
//   S_DONE | one-cycle completion; done_o high, err_o reports failure
module mem_access_unit #(
   parameter logic [31:0] MEM_BASE = 32'd1024,
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic                     mem_wr_i,
   input  logic                     byte_op_i,
   input  logic [31:0]              alu_out_i,
   input  logic [31:0]              wr_data_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic [31:0]              rd_data_o,
   mem_access_unit_if.master        mem
);

   localparam int unsigned     TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [32:0]     WINDOW   = 33'd4 << ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              err_q, err_d;
   logic [31:0]       rd_q, rd_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              byte_q, byte_d;
   logic [1:0]        lane_q, lane_d;

   logic [31:0] off;
   logic        below;
   logic        beyond;
   logic        misalign;
   logic        illegal;
   logic [3:0]  be_req;
   logic [31:0] wdata_req;
   logic [7:0]  rd_byte;

   // Request decode against the live inputs; only used in the cycle start_i is taken.
   always_comb begin
      off       = alu_out_i - MEM_BASE;
      below     = alu_out_i < MEM_BASE;
      beyond    = {1'b0, off} >= WINDOW;
      misalign  = !byte_op_i && (alu_out_i[1:0] != 2'b00);
      illegal   = below || beyond || misalign;
      be_req    = byte_op_i ? (4'b0001 << alu_out_i[1:0]) : 4'b1111;
      wdata_req = byte_op_i ? {4{wr_data_i[7:0]}} : wr_data_i;
   end

   always_comb begin
      rd_byte = 8'(mem.rdata >> {lane_q, 3'b000});
   end

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      rd_d    = rd_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      tmo_d   = tmo_q;
      byte_d  = byte_q;
      lane_d  = lane_q;

      case (state_q)
         S_IDLE: begin
            err_d = 1'b0;
            if (start_i) begin
               if (illegal) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
                  we_d    = mem_wr_i;
                  addr_d  = off[ADDR_W+1:2];
                  be_d    = be_req;
                  wdata_d = wdata_req;
                  byte_d  = byte_op_i;
                  lane_d  = alu_out_i[1:0];
                  tmo_d   = '0;
               end
            end
         end

         S_REQ: begin
            // The acknowledge takes priority over an expiring timeout in the same cycle.
            if (mem.ack) begin
               state_d = S_DONE;
               err_d   = 1'b0;
               if (!we_q) begin
                  rd_d = byte_q ? {24'h0, rd_byte} : mem.rdata;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end

            if (state_d == S_DONE) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               addr_d  = '0;
               be_d    = 4'b0000;
               wdata_d = 32'h0;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         err_q   <= 1'b0;
         rd_q    <= 32'h0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         wdata_q <= 32'h0;
         tmo_q   <= '0;
         byte_q  <= 1'b0;
         lane_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         tmo_q   <= tmo_d;
         byte_q  <= byte_d;
         lane_q  <= lane_d;
      end
   end

   assign busy_o    = (state_q != S_IDLE);
   assign done_o    = (state_q == S_DONE);
   assign err_o     = done_o && err_q;
   assign rd_data_o = rd_q;

   assign mem.req   = req_q;
   assign mem.we    = we_q;
   assign mem.addr  = addr_q;
   assign mem.be    = be_q;
   assign mem.wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected RAM requests and
// completions into queues; a monitor pops and compares them as the DUT presents them.
module tb_mem_access_unit;

   typedef struct {
      logic        err;
      logic [31:0] rd;
      string       name;
   } resp_t;

   typedef struct {
      logic        we;
      logic [9:0]  addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      string       name;
   } req_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        mem_wr;
   logic        byte_op;
   logic [31:0] alu_out;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rd_data;

   int total = 0;
   int bad   = 0;
   int last_req_len = 0;

   resp_t resp_q[$];
   req_t  req_q[$];

   mem_access_unit_if #(.ADDR_W(10)) mem_if ();

   mem_access_unit #(
      .MEM_BASE(32'd1024),
      .ADDR_W  (10),
      .TIMEOUT (16)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .mem_wr_i (mem_wr),
      .byte_op_i(byte_op),
      .alu_out_i(alu_out),
      .wr_data_i(wr_data),
      .busy_o   (busy),
      .done_o   (done),
      .err_o    (err),
      .rd_data_o(rd_data),
      .mem      (mem_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: compares RAM requests on their rising edge and completions on done.
   initial begin
      logic        req_prev;
      int          len;
      req_t        cur;
      logic [46:0] held;
      req_prev = 1'b0;
      len      = 0;
      held     = '0;
      forever begin
         @(negedge clk);
         if (mem_if.req) begin
            if (!req_prev) begin
               len  = 1;
               held = {mem_if.we, mem_if.addr, mem_if.be, mem_if.wdata};
               if (req_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_req: got addr %h want no request", mem_if.addr);
               end else begin
                  cur = req_q.pop_front();
                  chk({cur.name, "_we"},   32'(mem_if.we),   32'(cur.we));
                  chk({cur.name, "_addr"}, 32'(mem_if.addr), 32'(cur.addr));
                  chk({cur.name, "_be"},   32'(mem_if.be),   32'(cur.be));
                  if (cur.we) chk({cur.name, "_wdata"}, mem_if.wdata, cur.wdata);
               end
            end else begin
               len++;
               total++;
               if ({mem_if.we, mem_if.addr, mem_if.be, mem_if.wdata} !== held) begin
                  bad++;
                  $display("FAIL req_stable: got %h want %h",
                           {mem_if.we, mem_if.addr, mem_if.be, mem_if.wdata}, held);
               end
            end
         end else if (req_prev) begin
            last_req_len = len;
         end
         req_prev = mem_if.req;

         if (done) begin
            if (resp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 want done=0");
            end else begin
               resp_t r;
               r = resp_q.pop_front();
               chk({r.name, "_err"}, 32'(err), 32'(r.err));
               chk({r.name, "_rd"},  rd_data,  r.rd);
            end
         end else begin
            chk("err_without_done", 32'(err), 32'h0);
         end
      end
   end

   // Called at a negedge; returns at the negedge of the first cycle Busy is low again.
   // d = ack delay in cycles after mem_req rises (-1: never ack).
   task automatic do_op(input string name, input logic [31:0] alu, input logic wr,
                        input logic bop, input logic [31:0] wd, input logic [31:0] rdat,
                        input int d, input logic exp_err, input logic [31:0] exp_rd,
                        input logic [9:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input int exp_done, input bit poke);
      int seen;
      resp_t r;
      req_t  q;
      r.err  = exp_err;
      r.rd   = exp_rd;
      r.name = name;
      resp_q.push_back(r);
      if (exp_done != 1) begin
         q.we    = wr;
         q.addr  = exp_addr;
         q.be    = exp_be;
         q.wdata = exp_wd;
         q.name  = name;
         req_q.push_back(q);
      end
      start   = 1'b1;
      alu_out = alu;
      mem_wr  = wr;
      byte_op = bop;
      wr_data = wd;
      seen    = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         start        = 1'b0;
         mem_if.ack   = 1'b0;
         mem_if.rdata = 32'hFFFF_FFFF;
         if (done) begin
            seen = i;
            break;
         end
         if (i == 1) begin
            alu_out = ~alu;
            mem_wr  = ~wr;
            byte_op = ~bop;
            wr_data = ~wd;
         end
         if (poke && i == 2) begin
            start   = 1'b1;
            alu_out = 32'd1032;
            mem_wr  = 1'b0;
            byte_op = 1'b0;
         end
         if (d >= 0 && i == 1 + d) begin
            mem_if.ack   = 1'b1;
            mem_if.rdata = rdat;
         end
      end
      chk({name, "_latency"}, 32'(seen), 32'(exp_done));
      @(negedge clk);
      start = 1'b0;
      chk({name, "_busy_after"}, 32'(busy), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      mem_wr       = 1'b0;
      byte_op      = 1'b0;
      alu_out      = 32'h0;
      wr_data      = 32'h0;
      mem_if.ack   = 1'b0;
      mem_if.rdata = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_done",  32'(done), 32'h0);
      chk("rst_rd",    rd_data,   32'h0);
      chk("rst_req",   32'(mem_if.req), 32'h0);
      chk("rst_be",    32'(mem_if.be),  32'h0);
      chk("rst_addr",  32'(mem_if.addr), 32'h0);
      chk("rst_wdata", mem_if.wdata,    32'h0);

      do_op("lw_imm",    32'd1032, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 0,  1'b0, 32'hDEADBEEF, 10'd2,    4'b1111, 32'h0,        2,  1'b0);
      do_op("lb_delay3", 32'd1029, 1'b0, 1'b1, 32'h0,        32'h11223344, 3,  1'b0, 32'h00000033, 10'd1,    4'b0010, 32'h0,        5,  1'b1);
      do_op("sb",        32'd1027, 1'b1, 1'b1, 32'hABCDEF5A, 32'h99999999, 1,  1'b0, 32'h00000033, 10'd0,    4'b1000, 32'h5A5A5A5A, 3,  1'b0);
      do_op("sw_top",    32'd5116, 1'b1, 1'b0, 32'h12345678, 32'h99999999, 0,  1'b0, 32'h00000033, 10'd1023, 4'b1111, 32'h12345678, 2,  1'b0);
      do_op("lb_top",    32'd5119, 1'b0, 1'b1, 32'h0,        32'hA1B2C3D4, 0,  1'b0, 32'h000000A1, 10'd1023, 4'b1000, 32'h0,        2,  1'b0);
      do_op("err_align", 32'd1030, 1'b0, 1'b0, 32'h0,        32'h0,        -1, 1'b1, 32'h000000A1, 10'd0,    4'b0000, 32'h0,        1,  1'b0);
      do_op("err_below", 32'd1000, 1'b0, 1'b0, 32'h0,        32'h0,        -1, 1'b1, 32'h000000A1, 10'd0,    4'b0000, 32'h0,        1,  1'b0);
      do_op("err_above", 32'd5120, 1'b0, 1'b1, 32'h0,        32'h0,        -1, 1'b1, 32'h000000A1, 10'd0,    4'b0000, 32'h0,        1,  1'b0);
      do_op("err_1023",  32'd1023, 1'b1, 1'b1, 32'h77,       32'h0,        -1, 1'b1, 32'h000000A1, 10'd0,    4'b0000, 32'h0,        1,  1'b0);
      do_op("lw_base",   32'd1024, 1'b0, 1'b0, 32'h0,        32'h0BADF00D, 0,  1'b0, 32'h0BADF00D, 10'd0,    4'b1111, 32'h0,        2,  1'b0);
      do_op("timeout",   32'd1040, 1'b0, 1'b0, 32'h0,        32'h0,        -1, 1'b1, 32'h0BADF00D, 10'd4,    4'b1111, 32'h0,        17, 1'b0);
      chk("timeout_req_len", 32'(last_req_len), 32'd16);
      do_op("ack_at_lim", 32'd1044, 1'b0, 1'b1, 32'h0,       32'h55667788, 15, 1'b0, 32'h00000088, 10'd5,    4'b0001, 32'h0,        17, 1'b0);
      chk("ack_at_lim_req_len", 32'(last_req_len), 32'd16);

      // Reset in the middle of a request: mem_req drops, no completion, RdData cleared.
      begin
         req_t q;
         q.we    = 1'b0;
         q.addr  = 10'd4;
         q.be    = 4'b1111;
         q.wdata = 32'h0;
         q.name  = "rst_mid";
         req_q.push_back(q);
      end
      start   = 1'b1;
      alu_out = 32'd1040;
      mem_wr  = 1'b0;
      byte_op = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_req_before", 32'(mem_if.req), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_req",  32'(mem_if.req), 32'h0);
      chk("rst_mid_busy", 32'(busy), 32'h0);
      chk("rst_mid_rd",   rd_data, 32'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      do_op("after_rst", 32'd1032, 1'b0, 1'b0, 32'h0,        32'hCAFEF00D, 2,  1'b0, 32'hCAFEF00D, 10'd2,    4'b1111, 32'h0,        4,  1'b0);
      do_op("err_last",  32'd1026, 1'b1, 1'b0, 32'h1,        32'h0,        -1, 1'b1, 32'hCAFEF00D, 10'd0,    4'b0000, 32'h0,        1,  1'b0);

      repeat (3) @(negedge clk);
      chk("resp_q_empty", 32'(resp_q.size()), 32'h0);
      chk("req_q_empty",  32'(req_q.size()),  32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
